seq_det_ctrl: RTL and testbench
===============================

Name: seq_det_ctrl

Overview:
- Run-control block for the serial pattern detector.
- Holds a programmable pattern of 1..MAX_LEN bits, arms on `start`, and scans a serial bit stream for a fixed window or until `stop`.
- Counts overlapping matches and reports completion.
- Sits between the test or host control logic and the serial input; it generalises the fixed "101" detector into a configured, sequenced resource.

Parameters:
MAX_LEN, 8, maximum pattern length in bits
CNT_W, 8, width of match_count
WIN_W, 8, width of the window (bit-count) register

Ports:
clk  input  1  rising-edge clock
rst  input  1  synchronous active-high reset
cfg_we  input  1  write configuration; honoured only in IDLE
cfg_pattern  input  MAX_LEN  pattern; bit [len-1] is received first, bit 0 last
cfg_len  input  $clog2(MAX_LEN+1)  pattern length
cfg_window  input  WIN_W  number of valid bits to scan; 0 = unlimited
start  input  1  begin a run; honoured only in IDLE
stop  input  1  abort the run; honoured only in RUN
in  input  1  serial data bit
in_valid  input  1  `in` is sampled when high and state is RUN
det  output  1  one-cycle pulse per match
busy  output  1  high in RUN
done  output  1  one-cycle pulse in DONE
match_count  output  CNT_W  matches in the current or last run
overflow  output  1  sticky; match_count saturated

Behaviour:
- Reset (rst=1 at a clk edge) from any state, including mid-run:
  - state=IDLE; det=0, busy=0, done=0, match_count=0, overflow=0.
  - History, fill and bit counters cleared; config registers cleared to pattern=0, len=1, window=0.
- Clock and reset: one clock (clk); reset is synchronous and active-high (rst).
- Config:
  - cfg_we in IDLE latches pattern, len and window on the next edge.
  - cfg_we in RUN or DONE is ignored.
  - len is clamped: 0 becomes 1; values above MAX_LEN become MAX_LEN.
- States: IDLE, RUN, DONE.
- IDLE:
  - On start: clear history, fill counter, bit counter, match_count and overflow; go to RUN next cycle.
  - If cfg_we and start are asserted together, the config is latched first and the run uses the new config.
- RUN (busy=1):
  - Each cycle with in_valid=1 and stop=0: shift `in` into a MAX_LEN history register (newest at bit 0); increment fill (saturating at MAX_LEN) and the bit counter.
  - Match: fill (after the shift) ≥ len and history[len-1:0] == pattern[len-1:0]. Matches overlap; there is no history clear on a match.
  - Latency: for a bit sampled at edge t, det=1 during cycle t+1 only, and match_count increments at the same edge.
  - Saturation: at all-ones, match_count holds and overflow is set.
  - in_valid=0: history, counters and det are idle (det=0).
  - stop=1: go to DONE next cycle. A bit presented in the same cycle is discarded.
  - window≠0 and a valid bit makes bit counter == window: that bit is processed normally (a det pulse is still possible) and the state goes to DONE on the same edge.
  - window=0: the run continues until stop.
- DONE: done=1 and busy=0 for exactly one cycle, then IDLE.
  - start during DONE is ignored.
  - match_count and overflow hold until the next accepted start or a reset.
- in and in_valid are ignored outside RUN.

Test Plan:
1. Reset, then configure pattern=3'b101, len=3, window=12; start; feed valid bits 0,0,1,1,0,1,1,0,0,1,1,0 → single det pulse one cycle after the 6th bit; done pulse after the 12th bit; match_count=1; overflow=0.
2. Configure pattern=101, len=3, window=5; feed 1,0,1,0,1 → det after the 3rd and 5th bits (overlap); match_count=2; done one cycle after the 5th bit.
3. Configure pattern=000, len=3; feed 0,0,0,0 → no det after the 1st or 2nd bit (fill gating); det after the 3rd and 4th bits; count=2. Insert in_valid=0 gaps between bits → identical result.
4. Configure pattern=1, len=1, window=0; feed 300 valid ones; assert stop → match_count=255, overflow=1, done pulse. The bit presented with stop is not counted.
5. During RUN, assert cfg_we with pattern=0 and start → both ignored; run finishes with the original config. Immediately after done, start again → match_count clears to 0.
6. Assert rst for one cycle mid-RUN after 1 match → next cycle state=IDLE, busy=0, match_count=0, det=0; pattern reads back as 0, len=1.

Source files
------------

// File: rtl/seq_det_ctrl.sv
// seq_det_ctrl: run-control block for the serial pattern detector.
// Holds a programmable pattern of 1..MAX_LEN bits and arms on start. It then
// scans a serial bit stream for a fixed window of valid bits, or until stop,
// and counts overlapping matches.
//
// Ports:
//   clk, rst           rising-edge clock, synchronous active-high reset
//   cfg_we             latch cfg_pattern/cfg_len/cfg_window (IDLE only)
//   cfg_pattern        pattern; bit [len-1] received first, bit 0 last
//   cfg_len            pattern length, clamped to 1..MAX_LEN
//   cfg_window         valid bits to scan per run; 0 = run until stop
//   start              begin a run (IDLE only)
//   stop               abort the run (RUN only); a bit in that cycle is dropped
//   in, in_valid       serial data and its qualifier, sampled in RUN
//   det                one-cycle pulse per match
//   busy               high in RUN
//   done               one-cycle pulse when a run completes
//   match_count        matches in the current or last run (saturating)
//   overflow           sticky; a match arrived while match_count was saturated
module seq_det_ctrl #(
  parameter  int MAX_LEN = 8,
  parameter  int CNT_W   = 8,
  parameter  int WIN_W   = 8,
  localparam int LEN_W   = $clog2(MAX_LEN + 1)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               cfg_we,
  input  logic [MAX_LEN-1:0] cfg_pattern,
  input  logic [LEN_W-1:0]   cfg_len,
  input  logic [WIN_W-1:0]   cfg_window,
  input  logic               start,
  input  logic               stop,
  input  logic               in,
  input  logic               in_valid,
  output logic               det,
  output logic               busy,
  output logic               done,
  output logic [CNT_W-1:0]   match_count,
  output logic               overflow
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t             state_q, state_n;
  logic [MAX_LEN-1:0] pat_q, hist_q, hist_n, mask;
  logic [LEN_W-1:0]   len_q, len_c, fill_q, fill_n;
  logic [WIN_W-1:0]   win_q, bits_q, bits_n;
  logic [CNT_W-1:0]   cnt_q;
  logic               ovf_q, det_q;
  logic               take_bit, match;

  always_comb begin
    len_c = cfg_len;
    if (cfg_len == '0)
      len_c = LEN_W'(1);
    else if (cfg_len > LEN_W'(MAX_LEN))
      len_c = LEN_W'(MAX_LEN);
  end

  // Mask selects the low len bits of history/pattern for comparison.
  always_comb begin
    mask = '0;
    for (int unsigned i = 0; i < MAX_LEN; i++)
      mask[i] = (i < 32'(len_q));
  end

  always_comb begin
    take_bit = (state_q == RUN) && in_valid && !stop;
    hist_n   = {hist_q[MAX_LEN-2:0], in};
    fill_n   = (fill_q == LEN_W'(MAX_LEN)) ? fill_q : fill_q + LEN_W'(1);
    bits_n   = bits_q + WIN_W'(1);
    match    = take_bit && (fill_n >= len_q) && (((hist_n ^ pat_q) & mask) == '0);

    state_n = state_q;
    unique case (state_q)
      IDLE: if (start) state_n = RUN;
      RUN: begin
        if (stop)
          state_n = DONE;
        else if (take_bit && (win_q != '0) && (bits_n == win_q))
          state_n = DONE;
      end
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_n;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pat_q  <= '0;
      len_q  <= LEN_W'(1);
      win_q  <= '0;
      hist_q <= '0;
      fill_q <= '0;
      bits_q <= '0;
      cnt_q  <= '0;
      ovf_q  <= 1'b0;
      det_q  <= 1'b0;
    end else begin
      det_q <= match;
      if (state_q == IDLE && cfg_we) begin
        pat_q <= cfg_pattern;
        len_q <= len_c;
        win_q <= cfg_window;
      end
      if (state_q == IDLE && start) begin
        hist_q <= '0;
        fill_q <= '0;
        bits_q <= '0;
        cnt_q  <= '0;
        ovf_q  <= 1'b0;
      end
      if (take_bit) begin
        hist_q <= hist_n;
        fill_q <= fill_n;
        bits_q <= bits_n;
        if (match) begin
          if (cnt_q == '1) ovf_q <= 1'b1;
          else             cnt_q <= cnt_q + CNT_W'(1);
        end
      end
    end
  end

  assign det         = det_q;
  assign busy        = (state_q == RUN);
  assign done        = (state_q == DONE);
  assign match_count = cnt_q;
  assign overflow    = ovf_q;

endmodule

// File: tb/tb_seq_det_ctrl.sv
// Directed bench for seq_det_ctrl. Each step drives one cycle of inputs,
// advances a behavioural reference model, queues the expected outputs, and
// compares them against the DUT one cycle later.
module tb_seq_det_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       cfg_we = 1'b0;
  logic [7:0] cfg_pattern = '0;
  logic [3:0] cfg_len = '0;
  logic [7:0] cfg_window = '0;
  logic       start = 1'b0;
  logic       stop = 1'b0;
  logic       in = 1'b0;
  logic       in_valid = 1'b0;
  logic       det, busy, done, overflow;
  logic [7:0] match_count;

  seq_det_ctrl #(.MAX_LEN(8), .CNT_W(8), .WIN_W(8)) dut (
    .clk(clk), .rst(rst), .cfg_we(cfg_we), .cfg_pattern(cfg_pattern),
    .cfg_len(cfg_len), .cfg_window(cfg_window), .start(start), .stop(stop),
    .in(in), .in_valid(in_valid), .det(det), .busy(busy), .done(done),
    .match_count(match_count), .overflow(overflow)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       det, busy, done, ovf;
    logic [7:0] cnt;
  } exp_t;

  exp_t sb[$];
  int   nvec = 0;
  int   nerr = 0;
  int   nstep = 0;

  // Reference model state (0 = idle, 1 = run, 2 = done).
  int         m_state = 0;
  logic [7:0] m_pat = '0;
  int         m_len = 1;
  int         m_win = 0;
  int         m_bits = 0;
  int         m_cnt = 0;
  bit         m_ovf = 0;
  bit         m_det = 0;
  bit         hq[$];

  task automatic cmp(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    nvec++;
    assert (obs === exp_v)
    else begin
      nerr++;
      $error("FAIL %s (step %0d): observed %0h expected %0h", tag, nstep, obs, exp_v);
    end
  endtask

  task automatic model(input logic r, we, input logic [7:0] p, input logic [3:0] l,
                       input logic [7:0] w, input logic st, sp, d, v);
    bit hit;
    m_det = 0;
    if (r) begin
      m_state = 0; m_pat = '0; m_len = 1; m_win = 0;
      m_bits = 0; m_cnt = 0; m_ovf = 0; hq.delete();
    end else begin
      case (m_state)
        0: begin
          if (we) begin
            m_pat = p;
            m_len = (l == 0) ? 1 : ((l > 8) ? 8 : int'(l));
            m_win = int'(w);
          end
          if (st) begin
            hq.delete(); m_bits = 0; m_cnt = 0; m_ovf = 0; m_state = 1;
          end
        end
        1: begin
          if (sp) m_state = 2;
          else if (v) begin
            hq.push_back(d);
            if (hq.size() > 8) void'(hq.pop_front());
            m_bits++;
            hit = (hq.size() >= m_len);
            for (int k = 0; k < m_len; k++)
              if (hit && hq[hq.size() - 1 - k] != m_pat[k]) hit = 0;
            if (hit) begin
              m_det = 1;
              if (m_cnt == 255) m_ovf = 1;
              else m_cnt++;
            end
            if (m_win != 0 && m_bits == m_win) m_state = 2;
          end
        end
        default: m_state = 0;
      endcase
    end
  endtask

  task automatic step(input logic r, we, input logic [7:0] p, input logic [3:0] l,
                      input logic [7:0] w, input logic st, sp, d, v);
    exp_t e;
    rst = r; cfg_we = we; cfg_pattern = p; cfg_len = l; cfg_window = w;
    start = st; stop = sp; in = d; in_valid = v;
    model(r, we, p, l, w, st, sp, d, v);
    e.det = m_det; e.busy = (m_state == 1); e.done = (m_state == 2);
    e.cnt = 8'(m_cnt); e.ovf = m_ovf;
    sb.push_back(e);
    @(posedge clk);
    #1;
    nstep++;
    e = sb.pop_front();
    cmp("det", 32'(det), 32'(e.det));
    cmp("busy", 32'(busy), 32'(e.busy));
    cmp("done", 32'(done), 32'(e.done));
    cmp("match_count", 32'(match_count), 32'(e.cnt));
    cmp("overflow", 32'(overflow), 32'(e.ovf));
  endtask

  task automatic idle();                    step(0, 0, 8'h00, 4'd0, 8'd0, 0, 0, 0, 0); endtask
  task automatic do_rst();                  step(1, 0, 8'h00, 4'd0, 8'd0, 0, 0, 0, 0); endtask
  task automatic go();                      step(0, 0, 8'h00, 4'd0, 8'd0, 1, 0, 0, 0); endtask
  task automatic bitv(input logic d);       step(0, 0, 8'h00, 4'd0, 8'd0, 0, 0, d, 1); endtask
  task automatic cfg(input logic [7:0] p, input logic [3:0] l, input logic [7:0] w);
    step(0, 1, p, l, w, 0, 0, 0, 0);
  endtask
  task automatic cfg_go(input logic [7:0] p, input logic [3:0] l, input logic [7:0] w);
    step(0, 1, p, l, w, 1, 0, 0, 0);
  endtask

  logic [11:0] t1 = 12'b0011_0110_0110;  // bits sent MSB first: 0,0,1,1,0,1,1,0,0,1,1,0

  initial begin
    // 1: reset state, basic match, window completion
    do_rst();
    cmp("reset_busy", 32'(busy), 32'd0);
    cfg(8'b101, 4'd3, 8'd12);
    go();
    for (int i = 11; i >= 0; i--) begin
      bitv(t1[i]);
      if (i == 6) cmp("t1_det_after_6th", 32'(det), 32'd1);
    end
    cmp("t1_done", 32'(done), 32'd1);
    cmp("t1_count", 32'(match_count), 32'd1);
    idle();

    // 2: overlapping matches, config and start in the same cycle
    cfg_go(8'b101, 4'd3, 8'd5);
    bitv(1); bitv(0); bitv(1); bitv(0); bitv(1);
    cmp("t2_done", 32'(done), 32'd1);
    cmp("t2_count", 32'(match_count), 32'd2);
    idle();

    // 3: fill gating, then the same stream with in_valid gaps
    cfg_go(8'b000, 4'd3, 8'd4);
    bitv(0);
    cmp("t3_no_det_1st", 32'(det), 32'd0);
    bitv(0);
    cmp("t3_no_det_2nd", 32'(det), 32'd0);
    bitv(0); bitv(0);
    cmp("t3_count", 32'(match_count), 32'd2);
    idle();
    go();
    for (int i = 0; i < 4; i++) begin
      idle(); bitv(0);
    end
    cmp("t3_gap_count", 32'(match_count), 32'd2);
    idle();

    // 3b: length above MAX_LEN clamps to 8
    cfg_go(8'hFF, 4'd15, 8'd8);
    for (int i = 0; i < 8; i++) bitv(1);
    cmp("len_clamp_count", 32'(match_count), 32'd1);
    idle();

    // 4: saturation and stop with a bit present
    cfg_go(8'b1, 4'd1, 8'd0);
    for (int i = 0; i < 300; i++) bitv(1);
    step(0, 0, 8'h00, 4'd0, 8'd0, 0, 1, 1, 1);
    cmp("t4_count", 32'(match_count), 32'd255);
    cmp("t4_ovf", 32'(overflow), 32'd1);
    cmp("t4_done", 32'(done), 32'd1);
    idle();

    // 5: cfg_we/start ignored during RUN, start ignored in DONE
    cfg_go(8'b101, 4'd3, 8'd6);
    bitv(1); bitv(0); bitv(1);
    step(0, 1, 8'h00, 4'd3, 8'd0, 1, 0, 0, 0);
    bitv(0); bitv(1); bitv(0);
    cmp("t5_count", 32'(match_count), 32'd2);
    go();
    cmp("t5_start_in_done_ignored", 32'(busy), 32'd0);
    go();
    cmp("t5_restart_clears", 32'(match_count), 32'd0);
    step(0, 0, 8'h00, 4'd0, 8'd0, 0, 1, 0, 0);
    idle();

    // 6: reset mid-run restores default pattern=0, len=1
    cfg_go(8'b1, 4'd1, 8'd0);
    bitv(1); bitv(0);
    do_rst();
    cmp("t6_count_after_rst", 32'(match_count), 32'd0);
    go();
    bitv(0);
    cmp("t6_default_pattern_det", 32'(det), 32'd1);
    bitv(1);
    cmp("t6_default_pattern_nodet", 32'(det), 32'd0);
    idle();

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
